key_filter_57: RTL and testbench



---
 rtl/key_filter_57_pkg.sv | 24 ++
 rtl/key_filter_57_if.sv | 28 ++
 rtl/key_filter_57_ch.sv | 119 +++++++++++
 rtl/key_filter_57.sv | 44 ++++
 tb/tb_key_filter_57.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/key_filter_57_pkg.sv
// Shared definitions for the key conditioner: counter width helper,
// polarity constants and the debounce FSM state type.
package key_filter_pkg_57;

  localparam bit POL_ACTIVE_LOW  = 1'b1;
  localparam bit POL_ACTIVE_HIGH = 1'b0;

  // Normalised level of a key that is not pressed.
  localparam logic RELEASED_LEVEL = 1'b0;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } deb_state_e;

  // Bits needed to hold 0..max; at least one bit so a zero maximum still
  // yields a legal vector.
  function automatic int CNT_W(input int max);
    int w;
    w = $clog2(max + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_filter_57_if.sv
// Key pins in, conditioned level and event pulses out, one bit per channel.
interface key_filter_57_if #(
  parameter int CHANNELS = 4
) ();

  logic [CHANNELS-1:0] key_in_57;
  logic [CHANNELS-1:0] key_level_57;
  logic [CHANNELS-1:0] key_press_57;
  logic [CHANNELS-1:0] key_release_57;
  logic [CHANNELS-1:0] key_long_57;

  modport master (
    output key_in_57,
    input  key_level_57,
    input  key_press_57,
    input  key_release_57,
    input  key_long_57
  );

  modport slave (
    input  key_in_57,
    output key_level_57,
    output key_press_57,
    output key_release_57,
    output key_long_57
  );

endinterface

// File: rtl/key_filter_57_ch.sv
// One key channel: polarity normalise, 2-FF synchroniser, counter debounce,
// and hold/repeat counters driving registered press/release/long pulses.
module key_filter_ch_57
  import key_filter_pkg_57::*;
#(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter bit ACTIVE_LOW    = POL_ACTIVE_LOW
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int SW = CNT_W(STABLE_CYCLES);
  localparam int HW = CNT_W(LONG_CYCLES);
  localparam int RW = CNT_W(REPEAT_CYCLES);

  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_V      = HW'(LONG_CYCLES);
  localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_CYCLES - 1);

  logic          sync1, sync2;
  deb_state_e    state, state_nxt;
  logic [SW-1:0] deb_cnt, deb_cnt_nxt;
  logic          level_nxt;
  logic [HW-1:0] hold, hold_nxt;
  logic [RW-1:0] rep, rep_nxt;
  logic          long_nxt;

  // NOTE: every register here uses <= so all of them sample the same
  // pre-edge values; a blocking assignment would leak sync1 into sync2
  // in one cycle and collapse the synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1         <= RELEASED_LEVEL;
      sync2         <= RELEASED_LEVEL;
      state         <= ST_STABLE;
      deb_cnt       <= '0;
      level         <= RELEASED_LEVEL;
      hold          <= '0;
      rep           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      sync1         <= raw ^ ACTIVE_LOW;
      sync2         <= sync1;
      state         <= state_nxt;
      deb_cnt       <= deb_cnt_nxt;
      level         <= level_nxt;
      hold          <= hold_nxt;
      rep           <= rep_nxt;
      press_pulse   <= level_nxt & ~level;
      release_pulse <= ~level_nxt & level;
      long_pulse    <= long_nxt;
    end
  end

  // NOTE: each output of this block gets a default before the case, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    deb_cnt_nxt = '0;
    level_nxt   = level;
    case (state)
      ST_STABLE: begin
        if (sync2 != level) begin
          if (STABLE_CYCLES == 1) begin
            level_nxt = ~level;
          end else begin
            state_nxt   = ST_CHANGING;
            deb_cnt_nxt = SW'(1);
          end
        end
      end
      ST_CHANGING: begin
        // A single bounce back to the accepted level restarts from zero.
        if (sync2 == level) begin
          state_nxt = ST_STABLE;
        end else if (deb_cnt == STABLE_LAST) begin
          level_nxt = ~level;
          state_nxt = ST_STABLE;
        end else begin
          deb_cnt_nxt = deb_cnt + SW'(1);
        end
      end
      default: state_nxt = ST_STABLE;
    endcase
  end

  // Hold saturates at LONG_CYCLES; the repeat counter only runs once the
  // first long pulse has fired, and a release (even this cycle) clears both.
  always_comb begin
    hold_nxt = hold;
    rep_nxt  = rep;
    long_nxt = 1'b0;
    if (!level || !level_nxt) begin
      hold_nxt = '0;
      rep_nxt  = '0;
    end else if (hold != LONG_V) begin
      hold_nxt = hold + HW'(1);
      long_nxt = (hold_nxt == LONG_V);
    end else if (REPEAT_CYCLES > 0) begin
      if (rep == REPEAT_LAST) begin
        rep_nxt  = '0;
        long_nxt = 1'b1;
      end else begin
        rep_nxt = rep + RW'(1);
      end
    end
  end

endmodule

// File: rtl/key_filter_57.sv
// Multi-channel key conditioner: CHANNELS independent filter channels
// whose outputs are gathered onto the key bus.
module key_filter_57
  import key_filter_pkg_57::*;
#(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter bit ACTIVE_LOW    = POL_ACTIVE_LOW
) (
  input logic           clk_50m_57,
  input logic           rst_57,
  key_filter_57_if.slave bus
);

  logic [CHANNELS-1:0] level_v;
  logic [CHANNELS-1:0] press_v;
  logic [CHANNELS-1:0] release_v;
  logic [CHANNELS-1:0] long_v;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    key_filter_ch_57 #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_ch (
      .clk           (clk_50m_57),
      .rst           (rst_57),
      .raw           (bus.key_in_57[i]),
      .level         (level_v[i]),
      .press_pulse   (press_v[i]),
      .release_pulse (release_v[i]),
      .long_pulse    (long_v[i])
    );
  end

  assign bus.key_level_57   = level_v;
  assign bus.key_press_57   = press_v;
  assign bus.key_release_57 = release_v;
  assign bus.key_long_57    = long_v;

endmodule

// File: tb/tb_key_filter_57.sv
// Scoreboard bench: two instances (repeat on / repeat off) share the key pins;
// expected pulse events are queued by the stimulus and popped by a monitor.
module tb_key_filter_57;

  localparam int CH = 2;

  typedef struct {
    int cyc;
    int dut;
    int ch;
    int kind;   // 0 press, 1 release, 2 long
  } ev_t;

  logic clk;
  logic rst;
  logic [CH-1:0] key_in;
  int cyc;
  int checks;
  int errors;
  ev_t exp_q[$];
  logic [1:0][5:0] ev_vec;
  string kind_name[3] = '{"press", "release", "long"};

  key_filter_57_if #(.CHANNELS(CH)) bus_a ();
  key_filter_57_if #(.CHANNELS(CH)) bus_b ();

  assign bus_a.key_in_57 = key_in;
  assign bus_b.key_in_57 = key_in;

  key_filter_57 #(
    .CHANNELS(CH), .STABLE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8), .ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk_50m_57 (clk),
    .rst_57     (rst),
    .bus        (bus_a)
  );

  key_filter_57 #(
    .CHANNELS(CH), .STABLE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk_50m_57 (clk),
    .rst_57     (rst),
    .bus        (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  assign ev_vec[0] = {bus_a.key_long_57, bus_a.key_release_57, bus_a.key_press_57};
  assign ev_vec[1] = {bus_b.key_long_57, bus_b.key_release_57, bus_b.key_press_57};

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, actual, expected);
    end
  endtask

  task automatic expect_ev(input int c, input int d, input int ch, input int k);
    ev_t e;
    e.cyc = c; e.dut = d; e.ch = ch; e.kind = k;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int d, input int ch, input int k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: unexpected dut%0d ch%0d %s at cycle %0d", d, ch, kind_name[k], cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.dut != d || e.ch != ch || e.kind != k) begin
        errors++;
        $display("FAIL event: got dut%0d ch%0d %s at cycle %0d, expected dut%0d ch%0d %s at cycle %0d",
                 d, ch, kind_name[k], cyc, e.dut, e.ch, kind_name[e.kind], e.cyc);
      end
    end
  endtask

  // Monitor: every pulse seen on either instance must match the queue head.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++)
        for (int k = 0; k < 3; k++)
          if (ev_vec[d][k*CH + c]) observe(d, c, k);
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    key_in = 2'b11;

    // Reset with keys released: nothing may come out.
    wait_until(2);
    check("reset_level_a", {6'd0, bus_a.key_level_57}, 8'd0);
    check("reset_long_a", {6'd0, bus_a.key_long_57}, 8'd0);
    wait_until(3);
    rst = 1'b0;
    wait_until(9);
    check("idle_level_a", {6'd0, bus_a.key_level_57}, 8'd0);
    check("idle_level_b", {6'd0, bus_b.key_level_57}, 8'd0);

    // Clean press on ch0 at 10 -> accepted at 16; release at 20 -> 26.
    expect_ev(16, 0, 0, 0); expect_ev(16, 1, 0, 0);
    expect_ev(26, 0, 0, 1); expect_ev(26, 1, 0, 1);
    wait_until(10); key_in[0] = 1'b0;
    wait_until(15);
    check("clean_before_accept", {6'd0, bus_a.key_level_57}, 8'd0);
    wait_until(16);
    check("clean_level_a", {6'd0, bus_a.key_level_57}, 8'd1);
    check("clean_level_b", {6'd0, bus_b.key_level_57}, 8'd1);
    wait_until(20); key_in[0] = 1'b1;
    wait_until(26);
    check("clean_released", {6'd0, bus_a.key_level_57}, 8'd0);

    // Bouncing press: toggles every 2 cycles, settles pressed at 60 -> 66.
    // Bouncing release settles at 78 -> 84.
    expect_ev(66, 0, 0, 0); expect_ev(66, 1, 0, 0);
    expect_ev(84, 0, 0, 1); expect_ev(84, 1, 0, 1);
    for (int k = 0; k < 10; k++) begin
      wait_until(40 + 2*k);
      key_in[0] = k[0];
    end
    wait_until(59);
    check("bounce_no_accept", {6'd0, bus_a.key_level_57}, 8'd0);
    wait_until(60); key_in[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_until(70 + 2*k);
      key_in[0] = ~k[0];
    end
    wait_until(83);
    check("bounce_still_held", {6'd0, bus_a.key_level_57}, 8'd1);

    // 3-cycle glitch, one short of the debounce length.
    wait_until(100); key_in[0] = 1'b0;
    wait_until(103); key_in[0] = 1'b1;
    wait_until(110);
    check("glitch_level", {6'd0, bus_a.key_level_57}, 8'd0);

    // Long press on ch1: accepted 126, long +20 then every 8 on dut_a only,
    // level held 50 cycles then released at 176.
    expect_ev(126, 0, 1, 0); expect_ev(126, 1, 1, 0);
    expect_ev(146, 0, 1, 2); expect_ev(146, 1, 1, 2);
    expect_ev(154, 0, 1, 2);
    expect_ev(162, 0, 1, 2);
    expect_ev(170, 0, 1, 2);
    expect_ev(176, 0, 1, 1); expect_ev(176, 1, 1, 1);
    wait_until(120); key_in[1] = 1'b0;
    wait_until(170); key_in[1] = 1'b1;
    wait_until(180);
    check("long_released_a", {6'd0, bus_a.key_level_57}, 8'd0);

    // Reset 12 cycles into a hold; key stays pressed through reset.
    expect_ev(206, 0, 1, 0); expect_ev(206, 1, 1, 0);
    expect_ev(228, 0, 1, 0); expect_ev(228, 1, 1, 0);
    expect_ev(248, 0, 1, 2); expect_ev(248, 1, 1, 2);
    expect_ev(256, 0, 1, 2);
    expect_ev(258, 0, 1, 1); expect_ev(258, 1, 1, 1);
    wait_until(200); key_in[1] = 1'b0;
    wait_until(217);
    check("hold_before_reset", {6'd0, bus_a.key_level_57}, 8'd2);
    wait_until(218);
    #1 rst = 1'b1;
    #1;
    check("reset_drop_a", {6'd0, bus_a.key_level_57}, 8'd0);
    check("reset_drop_b", {6'd0, bus_b.key_level_57}, 8'd0);
    wait_until(222); rst = 1'b0;
    wait_until(227);
    check("reaccept_pending", {6'd0, bus_a.key_level_57}, 8'd0);
    wait_until(252); key_in[1] = 1'b1;

    wait_until(275);
    check("final_level_a", {6'd0, bus_a.key_level_57}, 8'd0);
    check("final_level_b", {6'd0, bus_b.key_level_57}, 8'd0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d expected events never seen, first at cycle %0d",
               exp_q.size(), exp_q[0].cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
